// File: rtl/dram_pkg.sv
// Shared types, default parameters and the wrapped beat-address helper for
// the burst DRAM model.
package dram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BEAT,
    GAP
  } state_t;

  localparam int unsigned DEF_ADDR_W        = 16;
  localparam int unsigned DEF_DATA_W        = 32;
  localparam int unsigned DEF_MEM_WORDS     = 4096;
  localparam int unsigned DEF_BURST_LEN     = 4;
  localparam int unsigned DEF_READ_LATENCY  = 8;
  localparam int unsigned DEF_WRITE_LATENCY = 6;
  localparam int unsigned DEF_BEAT_GAP      = 2;

  // Critical-word-first: the offset wraps inside the aligned burst block,
  // then the index folds onto the array depth.
  function automatic logic [31:0] wrap_index(input logic [31:0] addr,
                                             input logic [31:0] beat,
                                             input int unsigned burst_len,
                                             input int unsigned mem_words);
    logic [31:0] mask;
    logic [31:0] depth_mask;
    mask       = burst_len - 1;
    depth_mask = mem_words - 1;
    return ((addr & ~mask) | ((addr + beat) & mask)) & depth_mask;
  endfunction

endpackage

// File: rtl/dram_burst_array.sv
// Word array with synchronous read and byte-enabled write; contents are
// deliberately left untouched by reset.
module dram_burst_array
  import dram_pkg::*;
#(
  parameter int unsigned WORDS  = DEF_MEM_WORDS,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned IDX_W  = 12
) (
  input  logic                clock,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   q,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbyte_en
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clock) begin
    q <= mem[raddr];
    if (we) begin
      for (int unsigned b = 0; b < DATA_W / 8; b++) begin
        if (wbyte_en[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dram_burst_model.sv
// Main-memory bus model: ready/valid request channel, programmable latency,
// burst length and beat spacing, critical-word-first wrapping bursts.
module dram_burst_model
  import dram_pkg::*;
#(
  parameter int unsigned ADDR_W        = DEF_ADDR_W,
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned MEM_WORDS     = DEF_MEM_WORDS,
  parameter int unsigned BURST_LEN     = DEF_BURST_LEN,
  parameter int unsigned READ_LATENCY  = DEF_READ_LATENCY,
  parameter int unsigned WRITE_LATENCY = DEF_WRITE_LATENCY,
  parameter int unsigned BEAT_GAP      = DEF_BEAT_GAP
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbyte_en,
  output logic                wdata_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rdata_valid,
  output logic                done,
  output logic                busy
);

  localparam int unsigned IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned BEAT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned LAT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned GAP_W   = $clog2(BEAT_GAP + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [LAT_W-1:0]  RD_WAIT   = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0]  WR_WAIT   = LAT_W'(WRITE_LATENCY - 1);
  localparam logic [GAP_W-1:0]  GAP_WAIT  = GAP_W'(BEAT_GAP - 1);

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  beat_next;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [LAT_W-1:0]   accept_wait;

  logic [ADDR_W-1:0]  rd_base;
  logic [BEAT_W-1:0]  rd_beat;
  logic [IDX_W-1:0]   raddr;
  logic [IDX_W-1:0]   waddr;
  logic [DATA_W-1:0]  array_q;
  logic               we;

  assign beat_next   = beat_cnt + BEAT_W'(1);
  assign accept_wait = req_write ? WR_WAIT : RD_WAIT;

  // Read address runs one beat ahead so the registered array output lines
  // up with rdata_valid; while idle it tracks the incoming request.
  always_comb begin
    rd_base = (state == IDLE) ? req_addr : addr_q;
    rd_beat = (state == BEAT) ? beat_next : beat_cnt;
  end

  assign raddr = IDX_W'(wrap_index(32'(rd_base), 32'(rd_beat), BURST_LEN, MEM_WORDS));
  assign waddr = IDX_W'(wrap_index(32'(addr_q), 32'(beat_cnt), BURST_LEN, MEM_WORDS));
  assign we    = wdata_ready && !reset;
  assign rdata = rdata_valid ? array_q : '0;

  dram_burst_array #(
    .WORDS  (MEM_WORDS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock    (clock),
    .raddr    (raddr),
    .q        (array_q),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wbyte_en (wbyte_en)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      gap_cnt     <= '0;
      beat_cnt    <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      rdata_valid <= 1'b0;
      wdata_ready <= 1'b0;
      done        <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      wdata_ready <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            write_q   <= req_write;
            beat_cnt  <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            // A latency of one skips WAIT entirely.
            if (accept_wait == '0) begin
              state       <= BEAT;
              rdata_valid <= !req_write;
              wdata_ready <= req_write;
              done        <= (LAST_BEAT == '0);
            end else begin
              state   <= WAIT;
              lat_cnt <= accept_wait;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_W'(1)) begin
            state       <= BEAT;
            lat_cnt     <= '0;
            rdata_valid <= !write_q;
            wdata_ready <= write_q;
            done        <= (LAST_BEAT == '0);
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        BEAT: begin
          if (beat_cnt == LAST_BEAT) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            beat_cnt <= beat_next;
            if (GAP_WAIT == '0) begin
              rdata_valid <= !write_q;
              wdata_ready <= write_q;
              done        <= (beat_next == LAST_BEAT);
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_WAIT;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            state       <= BEAT;
            gap_cnt     <= '0;
            rdata_valid <= !write_q;
            wdata_ready <= write_q;
            done        <= (beat_cnt == LAST_BEAT);
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_burst_model.sv
// Bench for dram_burst_model: directed and randomized bursts checked cycle by
// cycle against a word-array reference model and the burst timing rules.
module tb_dram_burst_model;

  localparam int unsigned BL    = 4;
  localparam int unsigned RL    = 8;
  localparam int unsigned WL    = 6;
  localparam int unsigned GAP   = 2;
  localparam int unsigned WORDS = 4096;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wbyte_en;
  logic        wdata_ready, rdata_valid, done, busy;

  logic        s_req_valid, s_req_ready, s_req_write;
  logic [15:0] s_req_addr;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wbyte_en;
  logic        s_wdata_ready, s_rdata_valid, s_done, s_busy;

  always #5 clock = ~clock;

  dram_burst_model dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .wdata(wdata), .wbyte_en(wbyte_en),
    .wdata_ready(wdata_ready), .rdata(rdata), .rdata_valid(rdata_valid),
    .done(done), .busy(busy)
  );

  dram_burst_model #(.BURST_LEN(1), .BEAT_GAP(1), .READ_LATENCY(1)) dut_single (
    .clock(clock), .reset(reset), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_write(s_req_write), .req_addr(s_req_addr), .wdata(s_wdata), .wbyte_en(s_wbyte_en),
    .wdata_ready(s_wdata_ready), .rdata(s_rdata), .rdata_valid(s_rdata_valid),
    .done(s_done), .busy(s_busy)
  );

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  logic [31:0] mem_m [WORDS];
  bit          known [WORDS];
  logic [31:0] bw_data [BL];
  logic [3:0]  bw_be [BL];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Beat k of a burst starting at a: offset wraps within the aligned block.
  function automatic int unsigned beat_word(input logic [15:0] a, input int unsigned k);
    int unsigned base;
    base = int'(a) - (int'(a) % BL);
    return (base + ((int'(a) % BL) + k) % BL) % WORDS;
  endfunction

  // Runs one burst from request to the first idle cycle; abort_at != 0 pulses
  // reset in that relative cycle and checks that nothing further happens.
  task automatic do_burst(input bit wr, input logic [15:0] a, input bit hold,
                          input int unsigned abort_at);
    int unsigned lat, last, guard, k, w;
    bit beat;
    lat   = wr ? WL : RL;
    last  = lat + (BL - 1) * GAP;
    guard = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    while (!req_ready && guard < 200) begin
      step();
      guard++;
    end
    check("accept_wait", 64'(guard < 200), 64'd1);
    step();
    if (!hold) req_valid = 1'b0;
    for (int unsigned c = 1; c <= last + 1; c++) begin
      beat = (c >= lat) && ((c - lat) % GAP == 0) && (c <= last);
      k    = beat ? (c - lat) / GAP : 0;
      w    = beat_word(a, k);
      if (wr && beat) begin
        wdata    = bw_data[k];
        wbyte_en = bw_be[k];
      end else begin
        wdata    = $urandom;
        wbyte_en = 4'($urandom);
      end
      check("rdata_valid", 64'(rdata_valid), 64'(beat && !wr));
      check("wdata_ready", 64'(wdata_ready), 64'(beat && wr));
      check("done", 64'(done), 64'(c == last));
      check("req_ready", 64'(req_ready), 64'(c == last + 1));
      check("busy", 64'(busy), 64'(c != last + 1));
      if (beat && !wr && known[w]) check("rdata", 64'(rdata), 64'(mem_m[w]));
      if (beat && wr) begin
        for (int unsigned b = 0; b < 4; b++)
          if (bw_be[k][b]) mem_m[w][b*8 +: 8] = bw_data[k][b*8 +: 8];
        if (bw_be[k] == 4'hF) known[w] = 1'b1;
      end
      if (c == abort_at) begin
        req_valid = 1'b0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        check("abort_ready", 64'(req_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rvalid", 64'(rdata_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        for (int unsigned i = 0; i < 12; i++) begin
          step();
          check("abort_quiet", 64'({rdata_valid, wdata_ready, done}), 64'd0);
        end
        return;
      end
      if (c <= last) step();
    end
  endtask

  task automatic set_beats(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input logic [3:0] be0, input logic [3:0] be_rest);
    bw_data[0] = d0; bw_data[1] = d1; bw_data[2] = d2; bw_data[3] = d3;
    bw_be[0] = be0; bw_be[1] = be_rest; bw_be[2] = be_rest; bw_be[3] = be_rest;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit          wr, hold;
    logic [15:0] a;
    foreach (known[i]) known[i] = 1'b0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    wdata = '0; wbyte_en = '0;
    s_req_valid = 1'b0; s_req_write = 1'b0; s_req_addr = '0;
    s_wdata = '0; s_wbyte_en = '0;
    step();
    step();
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rvalid", 64'(rdata_valid), 64'd0);
    check("rst_wready", 64'(wdata_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    reset = 1'b0;
    step();

    // Critical word first: preload 0x40..0x43, read from 0x42.
    set_beats(32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333, 4'hF, 4'hF);
    do_burst(1'b1, 16'h0040, 1'b0, 0);
    do_burst(1'b0, 16'h0042, 1'b0, 0);

    set_beats(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 4'hF, 4'hF);
    do_burst(1'b1, 16'h0010, 1'b0, 0);
    do_burst(1'b0, 16'h0010, 1'b0, 0);

    // Single-byte update leaves the other bytes alone.
    set_beats(32'hAABB_CCDD, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 4'hF, 4'hF);
    do_burst(1'b1, 16'h0020, 1'b0, 0);
    set_beats(32'h0000_0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 4'b0000);
    do_burst(1'b1, 16'h0020, 1'b0, 0);
    do_burst(1'b0, 16'h0020, 1'b0, 0);

    // Request held high across bursts: back-to-back accepts only when idle.
    set_beats(32'h5555_0000, 32'h5555_1111, 32'h5555_2222, 32'h5555_3333, 4'hF, 4'hF);
    do_burst(1'b0, 16'h0041, 1'b1, 0);
    do_burst(1'b1, 16'h0013, 1'b1, 0);
    do_burst(1'b0, 16'h0010, 1'b0, 0);

    // Reset in the middle of a read, then of a write.
    do_burst(1'b0, 16'h0040, 1'b0, 10);
    do_burst(1'b0, 16'h0040, 1'b0, 0);
    set_beats(32'hC0C0_C0C0, 32'hC1C1_C1C1, 32'hC2C2_C2C2, 32'hC3C3_C3C3, 4'hF, 4'hF);
    do_burst(1'b1, 16'h0100, 1'b0, 0);
    set_beats(32'hD0D0_D0D0, 32'hD1D1_D1D1, 32'hD2D2_D2D2, 32'hD3D3_D3D3, 4'hF, 4'hF);
    do_burst(1'b1, 16'h0100, 1'b0, 11);
    do_burst(1'b0, 16'h0100, 1'b0, 0);

    // Aliasing of high address bits on the default instance.
    set_beats(32'h7777_0001, 32'h7777_0002, 32'h7777_0003, 32'h7777_0004, 4'hF, 4'hF);
    do_burst(1'b1, 16'h0FFD, 1'b0, 0);
    do_burst(1'b0, 16'hFFFF, 1'b0, 0);

    for (int unsigned n = 0; n < 40; n++) begin
      wr   = 1'($urandom);
      hold = 1'($urandom);
      a    = 16'($urandom) & 16'hF03F;
      for (int unsigned k = 0; k < BL; k++) begin
        bw_data[k] = $urandom;
        bw_be[k]   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      end
      do_burst(wr, a, hold, 0);
    end
    req_valid = 1'b0;
    step();

    // Single-beat instance: write word 0xFFF, read it back through 0x1FFF.
    s_req_valid = 1'b1; s_req_write = 1'b1; s_req_addr = 16'h0FFF;
    s_wdata = 32'h5A5A_1234; s_wbyte_en = 4'hF;
    check("s_idle_ready", 64'(s_req_ready), 64'd1);
    step();
    s_req_valid = 1'b0;
    for (int unsigned c = 1; c <= 7; c++) begin
      check("s_wready", 64'(s_wdata_ready), 64'(c == 6));
      check("s_wdone", 64'(s_done), 64'(c == 6));
      check("s_wreq_ready", 64'(s_req_ready), 64'(c == 7));
      if (c < 7) step();
    end
    s_req_valid = 1'b1; s_req_write = 1'b0; s_req_addr = 16'h1FFF;
    step();
    s_req_valid = 1'b0;
    check("s_rvalid", 64'(s_rdata_valid), 64'd1);
    check("s_rdone", 64'(s_done), 64'd1);
    check("s_rdata", 64'(s_rdata), 64'h5A5A_1234);
    check("s_rbusy", 64'(s_busy), 64'd1);
    step();
    check("s_rvalid_end", 64'(s_rdata_valid), 64'd0);
    check("s_ready_end", 64'(s_req_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dram_burst_model.md
# dram_burst_model

Parametrised, byte-writeable main-memory bus model. It has programmable access latency, burst length and inter-beat cycle time, and performs critical-word-first wrapping bursts. It sits behind the cache/memory-hierarchy controller in place of the single-word DRAM model. A ready/valid request channel and separate read/write data paths replace the bidirectional data bus.

## Interface
- ADDR_W, 16: word-address width.
- DATA_W, 32: data word width; multiple of 8.
- MEM_WORDS, 4096: array depth; power of 2, ≤ 2**ADDR_W.
- BURST_LEN, 4: beats per request; power of 2, ≥ 1.
- READ_LATENCY, 8: cycles from request accept to first read beat; ≥ 1.
- WRITE_LATENCY, 6: cycles from request accept to first write beat; ≥ 1.
- BEAT_GAP, 2: cycles between consecutive beats; ≥ 1.
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  model idle, can accept a request.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  critical word address.
- wdata  in  DATA_W  write beat data.
- wbyte_en  in  DATA_W/8  per-byte write enable.
- wdata_ready  out  1  write beat consumed this cycle.
- rdata  out  DATA_W  read beat data.
- rdata_valid  out  1  rdata holds a beat this cycle.
- done  out  1  pulse on the final beat of a burst.
- busy  out  1  burst in progress (inverse of req_ready).

## Operation
- States: IDLE, WAIT, BEAT, GAP. req_ready = (state == IDLE).
- Accept: req_valid && req_ready at a rising edge. req_write and req_addr are latched. IDLE → WAIT, with the latency counter loaded from READ_LATENCY or WRITE_LATENCY.
- WAIT → BEAT when the latency counter expires.
- BEAT → GAP if beats remain and BEAT_GAP > 1. BEAT → BEAT if beats remain and BEAT_GAP == 1. BEAT → IDLE on the last beat.
- GAP → BEAT after BEAT_GAP−1 cycles.
- Beat k address: base = latched addr with log2(BURST_LEN) LSBs cleared. Offset = (addr_lsbs + k) mod BURST_LEN. Array index = (base | offset) mod MEM_WORDS, i.e. high address bits are ignored.
- Read beat: rdata_valid = 1 and rdata = array word.
- Write beat: wdata_ready = 1. Bytes with wbyte_en set are written at the edge ending the beat. Bytes with wbyte_en clear keep their contents.
- done = 1 in the cycle of the last beat only, alongside rdata_valid or wdata_ready.
- req_valid while busy is ignored. The requester holds the request until accepted.
- Reset values: state IDLE, req_ready 1, busy 0, rdata_valid 0, wdata_ready 0, done 0, rdata 0, all counters 0.
- Reset mid-burst: aborts immediately with no further beats. Writes already completed remain. Array contents are never cleared by reset.
- BURST_LEN = 1: a single beat; WAIT → BEAT → IDLE.

## Timing
- Accept at edge ending cycle T. Read beat k is in cycle T + READ_LATENCY + k·BEAT_GAP.
- Write beat k is in cycle T + WRITE_LATENCY + k·BEAT_GAP.
- Last beat L = T + LAT + (BURST_LEN−1)·BEAT_GAP. req_ready is 1 again in cycle L+1, so back-to-back accept is possible at the edge ending L+1.
- The array has synchronous read. The FSM presents the beat-k address one cycle before beat k, so rdata is registered and aligned with rdata_valid.
- A read after a write to the same word, in a later burst, returns the written data.

## Structure
- Package dram_pkg holds the state enum (IDLE/WAIT/BEAT/GAP), default parameter constants, and the helper for wrapped beat-address computation.
- One sub-module, dram_burst_array: MEM_WORDS × DATA_W, synchronous read, byte-enable write, no reset.
- Top level contains the FSM, latency/gap/beat counters and address-wrap logic.

## Test plan
- Preload word 0x40..0x43 = A0..A3. Read addr 0x42, defaults. Accept at T → rdata A2, A3, A0, A1 at T+8, T+10, T+12, T+14. done at T+14. req_ready at T+15.
- Write addr 0x10, wdata 0x11111111/22../33../44.., wbyte_en 0xF. Beats at T+6, 8, 10, 12. Read back 0x10..0x13 → exact values in order.
- Word = 0xAABBCCDD. Write 0x00000011 with wbyte_en 0b0001 → read returns 0xAABBCC11.
- req_valid held high continuously → accepts only at cycles where req_ready = 1. No overlapping beats. Second burst first beat at L+1+READ_LATENCY.
- Assert reset at T+10 during a read burst → next cycle state IDLE, rdata_valid/done 0, req_ready 1. Previously written data intact on a subsequent read.
- Parameter sweep BURST_LEN = 1, BEAT_GAP = 1, READ_LATENCY = 1 → single beat at T+1 with done. Address 0x1FFF with MEM_WORDS = 4096 aliases to word 0xFFF.
